link_frame_receiver: RTL and testbench
======================================

Name: link_frame_receiver

Overview:
- Serial-link deserializer that feeds the slave's frame-voting/LCD path.
- Samples the two-lane link (PORT1/PORT2), detects start, shifts in one redundant frame, checks the stop condition.
- Presents the frame on a parallel bus with a one-cycle `recv_ok` strobe.
- Runs entirely in the link clock domain; the voting logic downstream consumes `recv_data`/`recv_ok`.

Parameters:
- FRAME_BITS, 49: frame length in bits (16 data + 16 inverted + 16 copy + 1 parity).
- SYNC_STAGES, 2: flip-flop stages on each lane input, minimum 2.

Ports:
- clk  input  1  link clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  receive enable; low forces IDLE.
- rx_port1  input  1  lane 1 (even bit indices); idle level 1.
- rx_port2  input  1  lane 2 (odd bit indices); idle level 1.
- recv_data  output  FRAME_BITS  last good frame, index 0 = first bit received, declared [0:FRAME_BITS-1].
- recv_ok  output  1  one-cycle pulse: `recv_data` just updated.
- frame_err  output  1  one-cycle pulse: stop condition violated.
- rx_busy  output  1  high while in DATA or STOP.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, bit counter=0, shift register=0.
  - `recv_data`=0, `recv_ok`=0, `frame_err`=0, `rx_busy`=0.
  - Synchronizer flops reset to 1, so reset release never fakes a start.
- Synchronizer: each lane passes SYNC_STAGES flops; the FSM sees only synced values s1/s2.
- NCYC = ceil(FRAME_BITS/2) = 25 data cycles. In each data cycle k (0..NCYC-1):
  - bit[2k] = s1.
  - bit[2k+1] = s2, written only if 2k+1 < FRAME_BITS. For odd FRAME_BITS, s2 in the last cycle is don't-care and discarded.
- FSM:
  - IDLE: if en && s1==0 && s2==0, go to DATA with cnt=0. A single lane low is a glitch: stay IDLE, no error.
  - DATA: shift the pair in, cnt++. When cnt==NCYC-1, shift the final pair and go to STOP.
  - STOP:
    - if s1==1 && s2==1: `recv_data` <= shift register, `recv_ok` <= 1.
    - otherwise: `frame_err` <= 1 and `recv_data` unchanged.
    - Either way, go to IDLE.
- Back-to-back frames: IDLE may detect a new start on the cycle immediately after STOP. No mandatory gap.
- `recv_ok` and `frame_err` are registered, mutually exclusive, and high for exactly one cycle.
- Latency: edge 0 samples start at the pins. The FSM enters DATA at edge SYNC_STAGES. `recv_ok` is high after edge SYNC_STAGES+NCYC+1 (edge 28 for defaults).
- `recv_data` is stable between `recv_ok` pulses. Errored or aborted frames never modify it.
- en deasserted in DATA/STOP: return to IDLE next edge, discard the partial frame, raise neither `recv_ok` nor `frame_err`.
- Reset mid-frame: immediate return to reset values. The partial frame is lost.
- `rx_busy` = (state != IDLE), registered with the state.

Decomposition:
- Shared package `link_pkg`: FRAME_BITS default, NCYC derivation function, state encoding (IDLE/DATA/STOP), lane idle level constant.
- Transmitter and receiver both reuse this package.
- One natural sub-module: `link_sync`, a parameterized SYNC_STAGES-deep synchronizer with asynchronous reset-to-1, instantiated once per lane.

Test Plan:
- Good frame: payload d=16'hA5C3 sent as {d,~d,d,~^d}, stop high.
  - Expect `recv_ok`=1 for one cycle after edge 28.
  - Expect `recv_data`[0:15]=16'hA5C3, [16:31]=16'h5A3C, [48]=~^16'hA5C3.
  - Expect `frame_err`=0.
- Bad stop: same frame with lane 2 low during the stop cycle.
  - Expect `frame_err` pulse after edge 28, `recv_ok`=0, `recv_data` still equal to the previous frame (0 after reset).
- Glitch in IDLE: lane 1 low for 3 cycles while lane 2 stays high.
  - Expect `rx_busy`=0 throughout and no pulses.
- Back-to-back: frame 16'h1234 immediately followed by 16'hFFFF (new start the pin cycle after stop).
  - Expect two `recv_ok` pulses 27 cycles apart, with data 16'h1234 then 16'hFFFF.
- Abort: en dropped at data cycle 10, then raised, then a full frame 16'h0F0F sent.
  - Expect no pulse for the aborted frame and one `recv_ok` with 16'h0F0F.
- Reset mid-frame: rst asserted at data cycle 12 and released.
  - Expect all outputs 0 immediately, no spurious start at reset release, and the next full frame received correctly.

Source files
------------

// File: rtl/link_pkg.sv
// Shared definitions for the two-lane serial link (transmitter and receiver).
// Holds the frame length default, cycle-count derivation and FSM encoding.
package link_pkg;

    localparam int   FRAME_BITS_DEF = 49;
    localparam logic LANE_IDLE      = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_STOP = 2'd2
    } link_state_t;

    // Two bits move per link cycle, so an odd frame needs one half-used cycle.
    function automatic int ncyc(input int frame_bits);
        return (frame_bits + 1) / 2;
    endfunction

endpackage

// File: rtl/link_frame_receiver_if.sv
// Pin-side and frame-side signals of the link receiver.
// The slave modport is the receiver; the master modport drives the lanes.
interface link_frame_receiver_if
    import link_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEF
) ();

    logic                    en;
    logic                    rx_port1;
    logic                    rx_port2;
    logic [0:FRAME_BITS-1]   recv_data;
    logic                    recv_ok;
    logic                    frame_err;
    logic                    rx_busy;

    modport master (
        output en, rx_port1, rx_port2,
        input  recv_data, recv_ok, frame_err, rx_busy
    );

    modport slave (
        input  en, rx_port1, rx_port2,
        output recv_data, recv_ok, frame_err, rx_busy
    );

endinterface

// File: rtl/link_sync.sv
// Multi-stage lane synchronizer; resets to the lane idle level so that
// reset release can never look like a start condition.
module link_sync
    import link_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= {STAGES{LANE_IDLE}};
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/link_frame_receiver.sv
// Two-lane link deserializer: detects start, collects one frame, checks stop
// and publishes the frame with a one-cycle recv_ok (or frame_err) pulse.
module link_frame_receiver
    import link_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    link_frame_receiver_if.slave  bus
);

    localparam int NCYC  = ncyc(FRAME_BITS);
    localparam int CNT_W = $clog2(NCYC + 1);

    logic s1;
    logic s2;

    link_sync #(.STAGES(SYNC_STAGES)) u_sync1 (.clk(clk), .rst(rst), .d(bus.rx_port1), .q(s1));
    link_sync #(.STAGES(SYNC_STAGES)) u_sync2 (.clk(clk), .rst(rst), .d(bus.rx_port2), .q(s2));

    link_state_t           state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [0:FRAME_BITS-1] shift_reg, shift_next;
    logic [0:FRAME_BITS-1] recv_data_reg, recv_data_next;
    logic                  recv_ok_reg, recv_ok_next;
    logic                  frame_err_reg, frame_err_next;
    logic                  rx_busy_reg;
    logic                  shift_load;

    assign shift_load = (state_reg == ST_DATA) && bus.en;

    // Bit 2k comes from lane 1 and bit 2k+1 from lane 2 during data cycle k;
    // an odd frame simply has no slot for lane 2 in its last cycle.
    genvar gi;
    generate
        for (gi = 0; gi < FRAME_BITS; gi++) begin : g_bit
            if ((gi % 2) == 0) begin : g_even
                assign shift_next[gi] = (shift_load && cnt_reg == CNT_W'(gi / 2)) ? s1 : shift_reg[gi];
            end else begin : g_odd
                assign shift_next[gi] = (shift_load && cnt_reg == CNT_W'(gi / 2)) ? s2 : shift_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            recv_data_reg <= '0;
            recv_ok_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            rx_busy_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shift_reg     <= shift_next;
            recv_data_reg <= recv_data_next;
            recv_ok_reg   <= recv_ok_next;
            frame_err_reg <= frame_err_next;
            rx_busy_reg   <= (state_next != ST_IDLE);
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.en && !s1 && !s2) begin
                    state_next = ST_DATA;
                    cnt_next   = '0;
                end
            end
            ST_DATA: begin
                if (!bus.en) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == CNT_W'(NCYC - 1)) begin
                    state_next = ST_STOP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_STOP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Disabled receiver drops a frame silently, even in the stop cycle.
    always_comb begin
        recv_ok_next   = (state_reg == ST_STOP) && bus.en && s1 && s2;
        frame_err_next = (state_reg == ST_STOP) && bus.en && !(s1 && s2);
        recv_data_next = recv_ok_next ? shift_reg : recv_data_reg;
    end

    assign bus.recv_data = recv_data_reg;
    assign bus.recv_ok   = recv_ok_reg;
    assign bus.frame_err = frame_err_reg;
    assign bus.rx_busy   = rx_busy_reg;

endmodule

// File: tb/tb_link_frame_receiver.sv
// Directed bench for link_frame_receiver: good/bad frames, glitch, back-to-back,
// enable abort and mid-frame reset, with hand-computed expected frames.
module tb_link_frame_receiver;

    localparam int FB = 49;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   ok_n  = 0;
    int   err_n = 0;
    int   ok_cyc[$];
    logic [0:FB-1] ok_dat[$];

    link_frame_receiver_if #(.FRAME_BITS(FB)) bus ();

    link_frame_receiver #(.FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (bus.recv_ok === 1'b1) begin
            ok_cyc.push_back(cyc);
            ok_dat.push_back(bus.recv_data);
            ok_n++;
            $display("rx frame ok   cyc=%0d data=%h", cyc, bus.recv_data);
        end
        if (bus.frame_err === 1'b1) begin
            err_n++;
            $display("rx frame err  cyc=%0d", cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic p1, input logic p2);
        bus.rx_port1 = p1;
        bus.rx_port2 = p2;
        @(posedge clk);
        #1;
    endtask

    // Start pair, 25 data pairs, stop pair: leaves the bench just after edge 26.
    task automatic send_frame(input logic [15:0] d, input logic stop2);
        logic [0:FB-1] f;
        logic          p2;
        f = {d, ~d, d, ~^d};
        tick(1'b0, 1'b0);
        for (int k = 0; k < 25; k++) begin
            if (2 * k + 1 < FB) p2 = f[2 * k + 1];
            else                p2 = 1'b1;
            tick(f[2 * k], p2);
        end
        tick(1'b1, stop2);
    endtask

    initial begin
        logic [0:FB-1] exp_a5c3;
        logic [0:FB-1] exp_1234;
        logic [0:FB-1] exp_ffff;
        logic [0:FB-1] exp_0f0f;
        logic [0:FB-1] exp_8001;
        int            n0;
        int            e0;

        exp_a5c3 = {16'hA5C3, 16'h5A3C, 16'hA5C3, 1'b1};
        exp_1234 = {16'h1234, 16'hEDCB, 16'h1234, 1'b0};
        exp_ffff = {16'hFFFF, 16'h0000, 16'hFFFF, 1'b1};
        exp_0f0f = {16'h0F0F, 16'hF0F0, 16'h0F0F, 1'b1};
        exp_8001 = {16'h8001, 16'h7FFE, 16'h8001, 1'b1};

        bus.en       = 1'b0;
        bus.rx_port1 = 1'b1;
        bus.rx_port2 = 1'b1;
        #2;
        check("rst_data",  64'(bus.recv_data), 64'd0);
        check("rst_ok",    64'(bus.recv_ok),   64'd0);
        check("rst_err",   64'(bus.frame_err), 64'd0);
        check("rst_busy",  64'(bus.rx_busy),   64'd0);
        @(posedge clk); #1;
        rst    = 1'b0;
        bus.en = 1'b1;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);

        // Bad stop right after reset: data must stay at its reset value.
        send_frame(16'hA5C3, 1'b0);
        tick(1'b1, 1'b1);
        check("bad_busy_e27", 64'(bus.rx_busy),   64'd1);
        check("bad_err_e27",  64'(bus.frame_err), 64'd0);
        tick(1'b1, 1'b1);
        check("bad_err_e28",  64'(bus.frame_err), 64'd1);
        check("bad_ok_e28",   64'(bus.recv_ok),   64'd0);
        check("bad_data_e28", 64'(bus.recv_data), 64'd0);
        tick(1'b1, 1'b1);
        check("bad_err_e29",  64'(bus.frame_err), 64'd0);

        // Good frame.
        send_frame(16'hA5C3, 1'b1);
        tick(1'b1, 1'b1);
        check("good_ok_e27",   64'(bus.recv_ok),   64'd0);
        tick(1'b1, 1'b1);
        check("good_ok_e28",   64'(bus.recv_ok),   64'd1);
        check("good_err_e28",  64'(bus.frame_err), 64'd0);
        check("good_data_e28", 64'(bus.recv_data), 64'(exp_a5c3));
        tick(1'b1, 1'b1);
        check("good_ok_e29",   64'(bus.recv_ok),   64'd0);
        check("good_busy_e29", 64'(bus.rx_busy),   64'd0);
        check("good_data_e29", 64'(bus.recv_data), 64'(exp_a5c3));

        // Single-lane glitch in IDLE.
        n0 = ok_n;
        e0 = err_n;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) tick(1'b0, 1'b1);
            else       tick(1'b1, 1'b1);
            check("glitch_busy", 64'(bus.rx_busy), 64'd0);
        end
        check("glitch_ok_cnt",  64'(ok_n),  64'(n0));
        check("glitch_err_cnt", 64'(err_n), 64'(e0));

        // Back-to-back frames with no gap.
        n0 = ok_n;
        e0 = err_n;
        send_frame(16'h1234, 1'b1);
        send_frame(16'hFFFF, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        check("b2b_ok_cnt",  64'(ok_n),  64'(n0 + 2));
        check("b2b_err_cnt", 64'(err_n), 64'(e0));
        if (ok_n >= n0 + 2) begin
            check("b2b_spacing", 64'(ok_cyc[n0 + 1] - ok_cyc[n0]), 64'd27);
            check("b2b_data0",   64'(ok_dat[n0]),     64'(exp_1234));
            check("b2b_data1",   64'(ok_dat[n0 + 1]), 64'(exp_ffff));
        end
        check("b2b_data_out", 64'(bus.recv_data), 64'(exp_ffff));

        // Enable dropped mid-frame, then a full frame.
        n0 = ok_n;
        e0 = err_n;
        tick(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(i[0], ~i[0]);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        check("abort_busy_pre", 64'(bus.rx_busy), 64'd1);
        bus.en = 1'b0;
        tick(1'b1, 1'b1);
        check("abort_busy_post", 64'(bus.rx_busy), 64'd0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        bus.en = 1'b1;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        check("abort_no_pulse", 64'(ok_n + err_n), 64'(n0 + e0));
        send_frame(16'h0F0F, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        check("abort_ok_cnt",  64'(ok_n),  64'(n0 + 1));
        check("abort_err_cnt", 64'(err_n), 64'(e0));
        check("abort_data",    64'(bus.recv_data), 64'(exp_0f0f));

        // Reset in the middle of a frame.
        tick(1'b0, 1'b0);
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b1);
        check("mrst_busy_pre", 64'(bus.rx_busy), 64'd1);
        bus.rx_port1 = 1'b1;
        bus.rx_port2 = 1'b1;
        rst = 1'b1;
        #1;
        check("mrst_data", 64'(bus.recv_data), 64'd0);
        check("mrst_ok",   64'(bus.recv_ok),   64'd0);
        check("mrst_err",  64'(bus.frame_err), 64'd0);
        check("mrst_busy", 64'(bus.rx_busy),   64'd0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        rst = 1'b0;
        n0 = ok_n;
        e0 = err_n;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1);
            check("mrst_release_busy", 64'(bus.rx_busy), 64'd0);
        end
        send_frame(16'h8001, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        check("mrst_ok_e28",   64'(bus.recv_ok),   64'd1);
        check("mrst_data_e28", 64'(bus.recv_data), 64'(exp_8001));
        tick(1'b1, 1'b1);
        check("mrst_ok_cnt",  64'(ok_n),  64'(n0 + 1));
        check("mrst_err_cnt", 64'(err_n), 64'(e0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
